imem_loader: RTL and testbench

Boot/reload controller for the pipelined MIPS core.
- Accepts a valid/ready stream of 32-bit instruction words and sequences their writes into the instruction memory write port (wr_instr / wr_en).
- Holds the pipeline in reset while loading, then releases it after a programmable hold interval.
- Sits between the external program source and instr_mem / the core reset net in top.

---
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader.sv | 206 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: stream, instruction-memory write port and status signals
// of the boot/reload loader. The loader connects through the slave modport;
// the program source / system top connects through the master modport.
interface imem_loader_if;
    logic        start_ldr_i;
    logic [15:0] len_ldr_i;
    logic        data_valid_ldr_i;
    logic [31:0] data_ldr_i;
    logic        data_ready_ldr_o;
    logic        wr_en_imem_ldr_o;
    logic [31:0] wr_addr_imem_ldr_o;
    logic [31:0] wr_instr_imem_ldr_o;
    logic        core_reset_ldr_o;
    logic        busy_ldr_o;
    logic        done_ldr_o;
    logic        err_ldr_o;
    logic [15:0] word_cnt_ldr_o;

    modport master (
        output start_ldr_i, len_ldr_i, data_valid_ldr_i, data_ldr_i,
        input  data_ready_ldr_o, wr_en_imem_ldr_o, wr_addr_imem_ldr_o,
               wr_instr_imem_ldr_o, core_reset_ldr_o, busy_ldr_o,
               done_ldr_o, err_ldr_o, word_cnt_ldr_o
    );

    modport slave (
        input  start_ldr_i, len_ldr_i, data_valid_ldr_i, data_ldr_i,
        output data_ready_ldr_o, wr_en_imem_ldr_o, wr_addr_imem_ldr_o,
               wr_instr_imem_ldr_o, core_reset_ldr_o, busy_ldr_o,
               done_ldr_o, err_ldr_o, word_cnt_ldr_o
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot/reload controller for the pipelined MIPS core.
// Streams instruction words into instr_mem, holds the core in reset while
// loading and for RST_HOLD cycles after the last write, then releases it.
// Optional macro LDR_TIMEOUT_EN: abort a stalled load after TIMEOUT_CYCLES
// beat-free cycles (sets err, returns to IDLE with the core still in reset).
module imem_loader #(
    parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1024,
    parameter int          RST_HOLD       = 4,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int                  HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
    localparam logic [16:0]         MAX_LEN   = 17'(MAX_WORDS);

    state_t            r_state;
    state_t            w_next_state;
    logic [15:0]       r_len;
    logic [15:0]       r_word_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_wr_en;
    logic [31:0]       r_wr_addr;
    logic [31:0]       r_wr_instr;
    logic              r_core_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_ready;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_len_legal;
    logic              w_load_start;
    logic              w_err_set;
    logic              w_timeout;

    assign w_ready     = (r_state == ST_LOAD);
    assign w_beat      = bus.data_valid_ldr_i && w_ready;
    assign w_last_beat = w_beat && ((r_word_cnt + 16'd1) == r_len);
    assign w_len_legal = (bus.len_ldr_i != 16'd0) && ({1'b0, bus.len_ldr_i} <= MAX_LEN);

`ifdef LDR_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] r_idle_cnt;

    assign w_timeout = w_ready && !w_beat && (r_idle_cnt == TO_LAST);

    // Count consecutive beat-free LOAD cycles; any beat or other state restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (!w_ready || w_beat) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TO_ONE;
        end
    end
`else
    // Timeout disabled: LOAD waits for the stream indefinitely.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus start-acceptance and error-set strobes.
    always_comb begin
        w_next_state = r_state;
        w_load_start = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (bus.start_ldr_i) begin
                    if (w_len_legal) begin
                        w_next_state = ST_LOAD;
                        w_load_start = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_LOAD: begin
                if (w_last_beat) begin
                    w_next_state = ST_HOLD;
                end else if (w_timeout) begin
                    w_next_state = ST_IDLE;
                    w_err_set    = 1'b1;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Write port: one-cycle-late copy of each accepted beat; address and data hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= IMEM_BASE;
            r_wr_instr <= 32'h0000_0000;
        end else begin
            r_wr_en <= w_beat;
            if (w_beat) begin
                r_wr_addr  <= IMEM_BASE + {14'd0, r_word_cnt, 2'b00};
                r_wr_instr <= bus.data_ldr_i;
            end else begin
                r_wr_addr  <= r_wr_addr;
                r_wr_instr <= r_wr_instr;
            end
        end
    end

    // Load bookkeeping: latched length, accepted-word count, sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len      <= 16'd0;
            r_word_cnt <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            if (w_load_start) begin
                r_len      <= bus.len_ldr_i;
                r_word_cnt <= 16'd0;
            end else if (w_beat) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end else begin
                r_word_cnt <= r_word_cnt;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_load_start) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
        end
    end

    // Hold interval counter: zero outside HOLD, counts cycles spent in HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_HOLD) begin
            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
        end else begin
            r_hold_cnt <= '0;
        end
    end

    // Status outputs registered from the next state so they change with the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_core_reset <= (w_next_state != ST_RUN);
            r_busy       <= (w_next_state == ST_LOAD) || (w_next_state == ST_HOLD);
            r_done       <= (r_state == ST_HOLD) && (w_next_state == ST_RUN);
        end
    end

    assign bus.data_ready_ldr_o    = w_ready;
    assign bus.wr_en_imem_ldr_o    = r_wr_en;
    assign bus.wr_addr_imem_ldr_o  = r_wr_addr;
    assign bus.wr_instr_imem_ldr_o = r_wr_instr;
    assign bus.core_reset_ldr_o    = r_core_reset;
    assign bus.busy_ldr_o          = r_busy;
    assign bus.done_ldr_o          = r_done;
    assign bus.err_ldr_o           = r_err;
    assign bus.word_cnt_ldr_o      = r_word_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven directed bench for imem_loader plus
// hand-written sequences for reload, reset mid-load and the stalled stream.
module tb_imem_loader;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    imem_loader_if bus ();

    imem_loader #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] W0   = 32'h2008_0005;
    localparam logic [31:0] W1   = 32'h2009_0007;
    localparam logic [31:0] W2   = 32'h0109_5020;
    localparam logic [31:0] WA   = 32'hAAAA_0001;
    localparam logic [31:0] WB   = 32'hBBBB_0002;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct {
        string       name;
        logic        start;
        logic [15:0] len;
        logic        valid;
        logic [31:0] data;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_rdy;
        logic        e_cr;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string nm, input logic st, input logic [15:0] ln,
                                input logic vl, input logic [31:0] dt, input logic we,
                                input logic [31:0] ad, input logic [31:0] ins, input logic rdy,
                                input logic cr, input logic bsy, input logic dn, input logic er,
                                input logic [15:0] cnt);
        vec_t v;
        v.name = nm; v.start = st; v.len = ln; v.valid = vl; v.data = dt;
        v.e_we = we; v.e_addr = ad; v.e_instr = ins; v.e_rdy = rdy; v.e_cr = cr;
        v.e_busy = bsy; v.e_done = dn; v.e_err = er; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Compare every status output; address/data only matter when a write is expected.
    task automatic chk_all(input string nm, input logic we, input logic [31:0] ad,
                           input logic [31:0] ins, input logic rdy, input logic cr,
                           input logic bsy, input logic dn, input logic er, input logic [15:0] cnt);
        chk({nm, ".wr_en"},    {31'd0, bus.wr_en_imem_ldr_o}, {31'd0, we});
        if (we) begin
            chk({nm, ".wr_addr"},  bus.wr_addr_imem_ldr_o,  ad);
            chk({nm, ".wr_instr"}, bus.wr_instr_imem_ldr_o, ins);
        end
        chk({nm, ".ready"},    {31'd0, bus.data_ready_ldr_o}, {31'd0, rdy});
        chk({nm, ".core_rst"}, {31'd0, bus.core_reset_ldr_o}, {31'd0, cr});
        chk({nm, ".busy"},     {31'd0, bus.busy_ldr_o},       {31'd0, bsy});
        chk({nm, ".done"},     {31'd0, bus.done_ldr_o},       {31'd0, dn});
        chk({nm, ".err"},      {31'd0, bus.err_ldr_o},        {31'd0, er});
        chk({nm, ".word_cnt"}, {16'd0, bus.word_cnt_ldr_o},   {16'd0, cnt});
    endtask

    task automatic drive(input logic st, input logic [15:0] ln, input logic vl, input logic [31:0] dt);
        bus.start_ldr_i      = st;
        bus.len_ldr_i        = ln;
        bus.data_valid_ldr_i = vl;
        bus.data_ldr_i       = dt;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        drive(1'b0, 16'd0, 1'b0, 32'd0);

        //            name            st ln     vl data  we addr   instr rdy cr bsy dn er cnt
        vq.push_back(mk("idle_len0",   1, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 16'd0));
        vq.push_back(mk("idle_valid",  0, 16'd0,    1, JUNK,  0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 16'd0));
        vq.push_back(mk("idle_start3", 1, 16'd3,    1, W0,    0, 32'h0, 32'h0, 0, 1, 0, 0, 1, 16'd0));
        vq.push_back(mk("load_w0",     0, 16'd0,    1, W0,    0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 16'd0));
        vq.push_back(mk("load_w1",     0, 16'd0,    1, W1,    1, 32'h0, W0,    1, 1, 1, 0, 0, 16'd1));
        vq.push_back(mk("load_w2",     0, 16'd0,    1, W2,    1, 32'h4, W1,    1, 1, 1, 0, 0, 16'd2));
        vq.push_back(mk("hold0",       1, 16'd1,    1, JUNK,  1, 32'h8, W2,    0, 1, 1, 0, 0, 16'd3));
        vq.push_back(mk("hold1",       0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 16'd3));
        vq.push_back(mk("hold2",       0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 16'd3));
        vq.push_back(mk("hold3",       0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 16'd3));
        vq.push_back(mk("run_len1025", 1, 16'd1025, 0, 32'd0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 16'd3));
        vq.push_back(mk("run_err",     0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 16'd3));
        vq.push_back(mk("run_start2",  1, 16'd2,    0, 32'd0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 16'd3));
        vq.push_back(mk("load_wa",     0, 16'd0,    1, WA,    0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 16'd0));
        vq.push_back(mk("gap0",        0, 16'd0,    0, 32'd0, 1, 32'h0, WA,    1, 1, 1, 0, 0, 16'd1));
        vq.push_back(mk("gap1",        0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 16'd1));
        vq.push_back(mk("gap2",        0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 16'd1));
        vq.push_back(mk("gap3",        0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 16'd1));
        vq.push_back(mk("gap4",        0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 16'd1));
        vq.push_back(mk("load_wb",     0, 16'd0,    1, WB,    0, 32'h0, 32'h0, 1, 1, 1, 0, 0, 16'd1));
        vq.push_back(mk("hold_b0",     0, 16'd0,    0, 32'd0, 1, 32'h4, WB,    0, 1, 1, 0, 0, 16'd2));
        vq.push_back(mk("hold_b1",     0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 16'd2));
        vq.push_back(mk("hold_b2",     0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 16'd2));
        vq.push_back(mk("hold_b3",     0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 16'd2));
        vq.push_back(mk("run_b",       0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 16'd2));
        vq.push_back(mk("run_b1",      0, 16'd0,    0, 32'd0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 16'd2));

        // Reset state, including address and data registers.
        repeat (2) @(negedge clk);
        chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("reset.wr_addr",  bus.wr_addr_imem_ldr_o,  32'h0);
        chk("reset.wr_instr", bus.wr_instr_imem_ldr_o, 32'h0);
        reset = 1'b0;

        // Table: check the current cycle's outputs, then drive this cycle's inputs.
        for (int i = 0; i < vq.size(); i++) begin
            chk_all(vq[i].name, vq[i].e_we, vq[i].e_addr, vq[i].e_instr, vq[i].e_rdy,
                    vq[i].e_cr, vq[i].e_busy, vq[i].e_done, vq[i].e_err, vq[i].e_cnt);
            drive(vq[i].start, vq[i].len, vq[i].valid, vq[i].data);
            @(negedge clk);
        end

        // Reload from RUN with len=1: reset reasserts next cycle, release 4 cycles after the write.
        drive(1'b1, 16'd1, 1'b0, 32'd0);
        @(negedge clk);
        chk_all("rl_load", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 16'd0, 1'b1, W1);
        @(negedge clk);
        drive(1'b0, 16'd0, 1'b0, 32'd0);
        chk_all("rl_write", 1'b1, 32'h0, W1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk_all($sformatf("rl_hold%0d", k), 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
        end
        @(negedge clk);
        chk_all("rl_run", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);

        // Reset during a len=4 load after two beats; later beats must be ignored.
        drive(1'b1, 16'd4, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b0, 16'd0, 1'b1, W0);
        @(negedge clk);
        drive(1'b0, 16'd0, 1'b1, W1);
        @(negedge clk);
        chk_all("rs_before", 1'b1, 32'h4, W1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2);
        drive(1'b0, 16'd0, 1'b1, W2);
        #2 reset = 1'b1;
        #1;
        chk_all("rs_async", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("rs_async.wr_addr",  bus.wr_addr_imem_ldr_o,  32'h0);
        chk("rs_async.wr_instr", bus.wr_instr_imem_ldr_o, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_all($sformatf("rs_after%0d", k), 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        end

        // len=MAX_WORDS is legal; one beat then a silent stream.
        drive(1'b1, 16'd1024, 1'b0, 32'd0);
        @(negedge clk);
        chk_all("max_load", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 16'd0, 1'b1, WA);
        @(negedge clk);
        drive(1'b0, 16'd0, 1'b0, 32'd0);
        chk_all("max_write", 1'b1, 32'h0, WA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
`ifdef LDR_TIMEOUT_EN
        repeat (7) @(negedge clk);
        chk_all("to_before", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
        @(negedge clk);
        chk_all("to_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
        repeat (5) @(negedge clk);
        chk_all("to_stay", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
`else
        repeat (100) @(negedge clk);
        chk_all("no_to", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
